pwm_gen_dt: RTL and testbench

PWM_GEN_DT -- requirements
Module: pwm_gen_dt

---
 rtl/pwm_gen_dt.sv | 136 +++++++++++++
 tb/tb_pwm_gen_dt.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_dt.sv
// Single complementary PWM leg: shadowed duty register, registered carrier
// compare, and a five-state gate FSM that inserts a both-off deadtime.
module pwm_gen_dt #(
  parameter int WIDTH = 16,
  parameter int DTW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] carrier,
  input  logic [WIDTH-1:0] carrier_max,
  input  logic [WIDTH-1:0] D,
  input  logic             load_event,
  input  logic [DTW-1:0]   deadtime,
  input  logic             enable,
  output logic             So_H,
  output logic             So_L,
  output logic [WIDTH-1:0] D_active
);

  typedef enum logic [2:0] {
    OFF,
    LOW,
    DT_H,
    HIGH,
    DT_L
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DTW-1:0]   cnt;
  logic [DTW-1:0]   cnt_nxt;
  logic [DTW-1:0]   dt_load;
  logic             raw;
  logic             raw_q;

  // Zero duty wins over the clamp, so a zero carrier_max cannot force the
  // high side on when no duty has been requested.
  always_comb begin
    raw = 1'b0;
    if (D_active != '0) begin
      raw = (D_active >= carrier_max) ? 1'b1 : (carrier < D_active);
    end
  end

  // A zero deadtime still spends one cycle in the DT state when leaving OFF.
  assign dt_load = (deadtime == '0) ? '0 : deadtime - DTW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = raw_q ? DT_H : DT_L;
          cnt_nxt   = dt_load;
        end
        LOW: begin
          if (raw_q) begin
            if (deadtime == '0) begin
              state_nxt = HIGH;
            end else begin
              state_nxt = DT_H;
              cnt_nxt   = dt_load;
            end
          end
        end
        DT_H: begin
          if (!raw_q) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = HIGH;
          end else begin
            cnt_nxt = cnt - DTW'(1);
          end
        end
        HIGH: begin
          if (!raw_q) begin
            if (deadtime == '0) begin
              state_nxt = LOW;
            end else begin
              state_nxt = DT_L;
              cnt_nxt   = dt_load;
            end
          end
        end
        DT_L: begin
          if (raw_q) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = LOW;
          end else begin
            cnt_nxt = cnt - DTW'(1);
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Gate commands decode the next state so they change on the same edge as
  // the state register and never glitch through combinational logic.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state, including the gate outputs, is cleared by the async
    // reset so both switches drop off without waiting for a clock.
    if (!rst_n) begin
      state    <= OFF;
      cnt      <= '0;
      raw_q    <= 1'b0;
      D_active <= '0;
      So_H     <= 1'b0;
      So_L     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let raw_q use the old D_active in the
      // same edge that loads a new one.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      raw_q <= raw;
      if (load_event) begin
        D_active <= D;
      end
      So_H <= (state_nxt == HIGH);
      So_L <= (state_nxt == LOW);
    end
  end

endmodule

// File: tb/tb_pwm_gen_dt.sv
// Directed and randomized bench for pwm_gen_dt against a timestamp-based
// model of the gate outputs.
module tb_pwm_gen_dt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] carrier;
  logic [15:0] carrier_max;
  logic [15:0] D;
  logic        load_event;
  logic [7:0]  deadtime;
  logic        enable;
  logic        So_H;
  logic        So_L;
  logic [15:0] D_active;

  pwm_gen_dt #(.WIDTH(16), .DTW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .carrier    (carrier),
    .carrier_max(carrier_max),
    .D          (D),
    .load_event (load_event),
    .deadtime   (deadtime),
    .enable     (enable),
    .So_H       (So_H),
    .So_L       (So_L),
    .D_active   (D_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the leg has a committed side (-1 none, 0 low, 1 high); a change of
  // side opens a both-off window that closes at a precomputed edge index.
  logic [15:0] m_dact;
  bit          m_rq;
  bit          waiting;
  bit          target;
  int          side;
  int          rel_edge;
  int          cyc;
  bit          prev_h;
  bit          prev_l;
  int          l_fall[$];
  int          l_rise[$];
  int          h_fall[$];
  int          h_rise[$];
  int          p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dact   = '0;
    m_rq     = 1'b0;
    waiting  = 1'b0;
    target   = 1'b0;
    side     = -1;
    rel_edge = 0;
    prev_h   = 1'b0;
    prev_l   = 1'b0;
  endtask

  task automatic tick();
    bit raw;
    int e;
    int n;
    raw = (m_dact == 0) ? 1'b0 : ((m_dact >= carrier_max) ? 1'b1 : (carrier < m_dact));
    e   = cyc + 1;
    n   = int'(deadtime);
    if (!enable) begin
      side    = -1;
      waiting = 1'b0;
    end else if (waiting) begin
      if (m_rq != target) begin
        side    = int'(m_rq);
        waiting = 1'b0;
      end else if (e >= rel_edge) begin
        side    = int'(target);
        waiting = 1'b0;
      end
    end else if (side < 0) begin
      waiting  = 1'b1;
      target   = m_rq;
      rel_edge = e + ((n == 0) ? 1 : n);
    end else if (side != int'(m_rq)) begin
      if (n == 0) begin
        side = int'(m_rq);
      end else begin
        waiting  = 1'b1;
        target   = m_rq;
        rel_edge = e + n;
      end
    end
    m_rq = raw;
    if (load_event) m_dact = D;
    @(posedge clk);
    #1;
    cyc++;
    check("so_h", So_H, 32'(!waiting && side == 1));
    check("so_l", So_L, 32'(!waiting && side == 0));
    check("d_active", D_active, m_dact);
    check("exclusive", So_H & So_L, 0);
    if (prev_l && !So_L) l_fall.push_back(cyc);
    if (!prev_l && So_L) l_rise.push_back(cyc);
    if (prev_h && !So_H) h_fall.push_back(cyc);
    if (!prev_h && So_H) h_rise.push_back(cyc);
    prev_h = So_H;
    prev_l = So_L;
  endtask

  // Triangle carrier 0..99,100,99..1 with a period of 200 clocks.
  task automatic gen_tick();
    carrier = (p < 100) ? 16'(p) : 16'(200 - p);
    p = (p + 1) % 200;
    tick();
  endtask

  task automatic load_at_valley(input logic [15:0] d);
    for (int i = 0; i < 200 && p != 0; i++) gen_tick();
    D          = d;
    load_event = 1'b1;
    gen_tick();
    load_event = 1'b0;
  endtask

  initial begin
    int k0, k40, k39, cnt_h, n_off, n_hi;
    bit saw_h, saw_off, found;
    int seq[20];

    // Reset state, including a load attempt while held in reset.
    rst_n = 1'b0; carrier = '0; carrier_max = 16'd100; D = '0;
    load_event = 1'b0; deadtime = 8'd5; enable = 1'b0; cyc = 0; p = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_so_h", So_H, 0);
    check("rst_so_l", So_L, 0);
    D = 16'd77; load_event = 1'b1; enable = 1'b1;
    @(posedge clk);
    #1;
    check("rst_d_active", D_active, 0);
    check("rst_so_h_en", So_H, 0);
    check("rst_so_l_en", So_L, 0);
    load_event = 1'b0; enable = 1'b0;
    rst_n = 1'b1;

    // Deadtime on a 0..100..0 ramp with D=40, deadtime=5.
    carrier = 16'd100; D = 16'd40; load_event = 1'b1;
    tick();
    load_event = 1'b0;
    enable = 1'b1;
    repeat (10) tick();
    check("startup_low", So_L, 1);
    l_fall.delete(); l_rise.delete(); h_fall.delete(); h_rise.delete();
    p = 0; k0 = 0; k40 = 0; k39 = 0;
    for (int i = 0; i < 220; i++) begin
      if (i == 0) k0 = cyc;
      if (i == 40) k40 = cyc;
      if (i == 161) k39 = cyc;
      gen_tick();
    end
    check("n_l_fall", l_fall.size(), 2);
    check("n_h_rise", h_rise.size(), 2);
    check("n_h_fall", h_fall.size(), 1);
    check("n_l_rise", l_rise.size(), 1);
    if (l_fall.size() == 2 && h_rise.size() == 2 && h_fall.size() == 1 && l_rise.size() == 1) begin
      check("up_l_fall", l_fall[0], k0 + 2);
      check("up_h_rise", h_rise[0], k0 + 7);
      check("mid_h_fall", h_fall[0], k40 + 2);
      check("mid_l_rise", l_rise[0], k40 + 7);
      check("dn_l_fall", l_fall[1], k39 + 2);
      check("dn_h_rise", h_rise[1], k39 + 7);
    end

    // Shadow load: D changes without load_event leave the duty untouched.
    D = 16'd60;
    cnt_h = 0;
    for (int i = 0; i < 200; i++) begin
      gen_tick();
      cnt_h += int'(So_H);
    end
    check("shadow_hold", D_active, 40);
    check("duty_40", cnt_h, 2 * 40 - 1 - 5);
    load_at_valley(16'd60);
    repeat (200) gen_tick();
    cnt_h = 0;
    for (int i = 0; i < 200; i++) begin
      gen_tick();
      cnt_h += int'(So_H);
    end
    check("shadow_new", D_active, 60);
    check("duty_60", cnt_h, 2 * 60 - 1 - 5);

    // Zero duty and clamp.
    load_at_valley(16'd0);
    repeat (200) gen_tick();
    saw_h = 1'b0;
    for (int i = 0; i < 200; i++) begin
      gen_tick();
      if (So_H) saw_h = 1'b1;
    end
    check("zero_no_h", saw_h, 0);
    check("zero_low", So_L, 1);
    load_at_valley(16'd100);
    repeat (50) gen_tick();
    cnt_h = 0;
    for (int i = 0; i < 200; i++) begin
      gen_tick();
      cnt_h += int'(So_H);
    end
    check("clamp_100", cnt_h, 200);
    load_at_valley(16'd150);
    repeat (50) gen_tick();
    cnt_h = 0;
    for (int i = 0; i < 200; i++) begin
      gen_tick();
      cnt_h += int'(So_H);
    end
    check("clamp_150", cnt_h, 200);

    // Enable dropped in HIGH, then re-raised.
    enable = 1'b0;
    gen_tick();
    check("en_off_h", So_H, 0);
    check("en_off_l", So_L, 0);
    repeat (3) gen_tick();
    enable = 1'b1;
    n_hi = 0; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      gen_tick();
      n_hi++;
      if (So_H) found = 1'b1;
    end
    check("en_resume_found", found, 1);
    check("en_resume_edges", n_hi, 6);

    // Reset asserted in the middle of DT_H.
    load_at_valley(16'd40);
    repeat (250) gen_tick();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      gen_tick();
      if (l_fall.size() > 0 && l_fall[l_fall.size() - 1] == cyc) found = 1'b1;
    end
    check("find_dt_h", found, 1);
    repeat (2) gen_tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_h", So_H, 0);
    check("async_rst_l", So_L, 0);
    check("async_rst_d", D_active, 0);
    @(posedge clk);
    #1;
    check("held_rst_h", So_H, 0);
    check("held_rst_l", So_L, 0);
    rst_n = 1'b1;
    model_reset();

    // Short pulse with deadtime=10, D=3: DT_H entered then aborted.
    deadtime = 8'd10; carrier = 16'd5; D = 16'd3; load_event = 1'b1;
    tick();
    load_event = 1'b0;
    repeat (20) tick();
    check("short_pre_low", So_L, 1);
    seq = '{4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    saw_h = 1'b0; saw_off = 1'b0;
    for (int i = 0; i < 20; i++) begin
      carrier = 16'(seq[i]);
      tick();
      if (So_H) saw_h = 1'b1;
      if (!So_H && !So_L) saw_off = 1'b1;
    end
    check("short_no_h", saw_h, 0);
    check("short_dt_h", saw_off, 1);
    check("short_back_low", So_L, 1);

    // Zero deadtime: complementary switching with no both-off cycle.
    deadtime = 8'd0;
    p = 0;
    load_at_valley(16'd40);
    repeat (20) gen_tick();
    n_off = 0;
    for (int i = 0; i < 400; i++) begin
      gen_tick();
      if (!So_H && !So_L) n_off++;
    end
    check("dt0_no_off", n_off, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) carrier_max = 16'($urandom_range(20, 300));
      carrier = 16'($urandom_range(0, int'(carrier_max) + 2));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       D = '0;
          1:       D = carrier_max + 16'($urandom_range(0, 5));
          default: D = 16'($urandom_range(1, int'(carrier_max)));
        endcase
        load_event = 1'b1;
      end else begin
        load_event = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) deadtime = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      tick();
    end
    load_event = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
